branch_resolve_unit: RTL and testbench

// - Execute-side partner of fetch_unit_with_btb. Tracks each fetched PC with its BTB prediction.
// - Resolves each prediction against the actual branch outcome from execute.
// - Drives the BTB update port (branch_taken_execute / pc_execute / target_pc_execute) and the

---
 rtl/branch_resolve_unit.sv | 174 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves fetch-time BTB predictions against execute outcomes
// Define BRU_STATS_EN to build the saturating branch/hit/correct counters.
module branch_resolve_unit #(
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_btb_hit,
    input  logic [31:0] fetch_predicted_pc,
    output logic        fetch_ready,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        branch_taken_execute,
    output logic [31:0] pc_execute,
    output logic [31:0] target_pc_execute,
    output logic        btb_update,
    output logic        btb_invalidate,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        underflow_err,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_correct
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] L_PINC  = AW'(1);

    typedef enum logic {S_RUN, S_RECOVER} state_t;

    state_t        r_state, w_state_next;
    logic [31:0]   r_rcnt, w_rcnt_next;
    logic [31:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_q_pred [DEPTH];
    logic          r_q_hit  [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;

    logic        r_bu, r_inv, r_flush, r_taken, r_uf;
    logic [31:0] r_pc_ex, r_tgt, r_redir;

    logic        w_ready, w_push, w_pop, w_mispredict;
    logic [31:0] w_head_pc, w_pn, w_an;

    assign w_push       = fetch_valid && w_ready;
    assign w_pop        = ex_valid && (r_count != '0) && (r_state == S_RUN);
    assign w_head_pc    = r_q_pc[r_rd_ptr];
    assign w_pn         = r_q_hit[r_rd_ptr] ? r_q_pred[r_rd_ptr] : w_head_pc + 32'd4;
    assign w_an         = (ex_is_branch && ex_taken) ? ex_target : w_head_pc + 32'd4;
    assign w_mispredict = (w_pn != w_an);

    always_comb begin
        w_state_next = r_state;
        w_rcnt_next  = r_rcnt;
        w_ready      = 1'b0;
        case (r_state)
            S_RUN: begin
                w_ready = (r_count < L_DEPTH);
                if (w_pop && w_mispredict && (RECOVER_CYCLES > 0)) begin
                    w_state_next = S_RECOVER;
                    w_rcnt_next  = 32'(RECOVER_CYCLES);
                end
            end
            S_RECOVER: begin
                w_rcnt_next = r_rcnt - 32'd1;
                if (r_rcnt <= 32'd1) w_state_next = S_RUN;
            end
        endcase
    end

    // Entry storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= fetch_pc;
            r_q_hit[r_wr_ptr]  <= fetch_btb_hit;
            r_q_pred[r_wr_ptr] <= fetch_predicted_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_rcnt   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_bu     <= 1'b0;
            r_inv    <= 1'b0;
            r_flush  <= 1'b0;
            r_taken  <= 1'b0;
            r_uf     <= 1'b0;
            r_pc_ex  <= '0;
            r_tgt    <= '0;
            r_redir  <= '0;
        end else begin
            r_state <= w_state_next;
            r_rcnt  <= w_rcnt_next;
            r_bu    <= 1'b0;
            r_inv   <= 1'b0;
            r_flush <= 1'b0;
            if (w_pop && w_mispredict) begin
                // Everything younger than the mispredicted entry is wrong-path.
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + L_PINC;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PINC;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + L_ONE;
                    2'b01:   r_count <= r_count - L_ONE;
                    default: r_count <= r_count;
                endcase
            end
            if (w_pop) begin
                if (ex_is_branch) begin
                    r_bu    <= 1'b1;
                    r_pc_ex <= w_head_pc;
                    r_taken <= ex_taken;
                    r_tgt   <= w_an;
                end else if (r_q_hit[r_rd_ptr]) begin
                    r_inv   <= 1'b1;
                    r_pc_ex <= w_head_pc;
                end
                if (w_mispredict) begin
                    r_flush <= 1'b1;
                    r_redir <= w_an;
                end
            end
            if (ex_valid && (r_count == '0) && (r_state == S_RUN)) r_uf <= 1'b1;
        end
    end

    assign fetch_ready          = w_ready;
    assign btb_update           = r_bu;
    assign btb_invalidate       = r_inv;
    assign flush                = r_flush;
    assign branch_taken_execute = r_taken;
    assign pc_execute           = r_pc_ex;
    assign target_pc_execute    = r_tgt;
    assign redirect_pc          = r_redir;
    assign underflow_err        = r_uf;

`ifdef BRU_STATS_EN
    logic [31:0] r_stat_b, r_stat_h, r_stat_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_b <= '0;
            r_stat_h <= '0;
            r_stat_c <= '0;
        end else if (w_pop && ex_is_branch) begin
            if (r_stat_b != 32'hFFFFFFFF) r_stat_b <= r_stat_b + 32'd1;
            if (r_q_hit[r_rd_ptr] && (r_stat_h != 32'hFFFFFFFF)) r_stat_h <= r_stat_h + 32'd1;
            if (r_q_hit[r_rd_ptr] && !w_mispredict && (r_stat_c != 32'hFFFFFFFF))
                r_stat_c <= r_stat_c + 32'd1;
        end
    end

    assign stat_branches = r_stat_b;
    assign stat_hits     = r_stat_h;
    assign stat_correct  = r_stat_c;
`else
    assign stat_branches = '0;
    assign stat_hits     = '0;
    assign stat_correct  = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and randomized checks of branch_resolve_unit
// Expected values come from constants and a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int RECOVER_CYCLES = 1;
`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid, fetch_btb_hit, fetch_ready;
    logic [31:0] fetch_pc, fetch_predicted_pc;
    logic        ex_valid, ex_is_branch, ex_taken;
    logic [31:0] ex_target;
    logic        branch_taken_execute, btb_update, btb_invalidate, flush, underflow_err;
    logic [31:0] pc_execute, target_pc_execute, redirect_pc;
    logic [31:0] stat_branches, stat_hits, stat_correct;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(DEPTH), .RECOVER_CYCLES(RECOVER_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_btb_hit(fetch_btb_hit),
        .fetch_predicted_pc(fetch_predicted_pc), .fetch_ready(fetch_ready),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
        .ex_target(ex_target), .branch_taken_execute(branch_taken_execute),
        .pc_execute(pc_execute), .target_pc_execute(target_pc_execute),
        .btb_update(btb_update), .btb_invalidate(btb_invalidate), .flush(flush),
        .redirect_pc(redirect_pc), .underflow_err(underflow_err),
        .stat_branches(stat_branches), .stat_hits(stat_hits), .stat_correct(stat_correct)
    );

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] pred;
    } ent_t;

    ent_t        mq[$];
    int          m_rec;
    logic        m_uf, m_bu, m_inv, m_fl, m_tk;
    logic [31:0] m_pc, m_tgt, m_rd, m_sb, m_sh, m_sc;

    task automatic model_reset();
        mq.delete();
        m_rec = 0; m_uf = 0; m_bu = 0; m_inv = 0; m_fl = 0; m_tk = 0;
        m_pc = 0; m_tgt = 0; m_rd = 0; m_sb = 0; m_sh = 0; m_sc = 0;
    endtask

    function automatic logic model_ready();
        return (mq.size() < DEPTH) && (m_rec == 0);
    endfunction

    task automatic idle_inputs();
        fetch_valid = 0; fetch_pc = 0; fetch_btb_hit = 0; fetch_predicted_pc = 0;
        ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_target = 0;
    endtask

    // Advance the model with the current inputs, then clock the DUT.
    task automatic step();
        ent_t        e;
        logic        push, pop;
        logic [31:0] pn, an;
        if (reset) begin
            model_reset();
        end else begin
            push = fetch_valid && model_ready();
            pop  = ex_valid && (mq.size() > 0) && (m_rec == 0);
            m_bu = 0; m_inv = 0; m_fl = 0;
            if (m_rec > 0) m_rec = m_rec - 1;
            else if (ex_valid && mq.size() == 0) m_uf = 1;
            if (pop) begin
                e  = mq.pop_front();
                pn = e.hit ? e.pred : e.pc + 32'd4;
                an = (ex_is_branch && ex_taken) ? ex_target : e.pc + 32'd4;
                if (ex_is_branch) begin
                    m_bu = 1; m_pc = e.pc; m_tk = ex_taken; m_tgt = an;
                    m_sb = m_sb + 1;
                    if (e.hit) m_sh = m_sh + 1;
                    if (e.hit && pn == an) m_sc = m_sc + 1;
                end else if (e.hit) begin
                    m_inv = 1; m_pc = e.pc;
                end
                if (pn != an) begin
                    m_fl = 1; m_rd = an;
                    mq.delete();
                    m_rec = RECOVER_CYCLES;
                    push = 0;
                end
            end
            if (push) mq.push_back('{fetch_pc, fetch_btb_hit, fetch_predicted_pc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic hit, input logic [31:0] pred);
        idle_inputs();
        fetch_valid = 1; fetch_pc = pc; fetch_btb_hit = hit; fetch_predicted_pc = pred;
        step();
        idle_inputs();
    endtask

    task automatic resolve(input logic br, input logic tk, input logic [31:0] tgt);
        idle_inputs();
        ex_valid = 1; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) step();
        checks++;
        if ({fetch_ready, flush, btb_update, btb_invalidate, underflow_err} !== 5'b10000)
            $display("FAIL reset_ctrl got %b want 10000",
                     {fetch_ready, flush, btb_update, btb_invalidate, underflow_err});
        checks++;
        if ({pc_execute, target_pc_execute, redirect_pc, branch_taken_execute} !== 97'd0)
            $display("FAIL reset_data got %h want 0",
                     {pc_execute, target_pc_execute, redirect_pc, branch_taken_execute});
        checks++;
        if ({stat_branches, stat_hits, stat_correct} !== 96'd0)
            $display("FAIL reset_stats got %h want 0", {stat_branches, stat_hits, stat_correct});
        if ({stat_branches, stat_hits, stat_correct} !== 96'd0) errors++;
        if ({pc_execute, target_pc_execute, redirect_pc, branch_taken_execute} !== 97'd0) errors++;
        if ({fetch_ready, flush, btb_update, btb_invalidate, underflow_err} !== 5'b10000) errors++;
    endtask

    task automatic test_taken_miss();
        do_reset();
        push_one(32'h14, 1'b0, 32'h0);
        resolve(1'b1, 1'b1, 32'h04);
        checks++;
        if ({btb_update, flush, branch_taken_execute, fetch_ready} !== 4'b1110) begin
            errors++;
            $display("FAIL miss_strobes got %b want 1110",
                     {btb_update, flush, branch_taken_execute, fetch_ready});
        end
        checks++;
        if ({pc_execute, target_pc_execute, redirect_pc} !== {32'h14, 32'h04, 32'h04}) begin
            errors++;
            $display("FAIL miss_data got %h want 000000140000000400000004",
                     {pc_execute, target_pc_execute, redirect_pc});
        end
        step();
        checks++;
        if ({btb_update, flush, fetch_ready} !== 3'b001) begin
            errors++;
            $display("FAIL miss_recover got %b want 001", {btb_update, flush, fetch_ready});
        end
    endtask

    task automatic test_taken_hit();
        do_reset();
        push_one(32'h14, 1'b1, 32'h04);
        resolve(1'b1, 1'b1, 32'h04);
        checks++;
        if ({btb_update, flush, fetch_ready, target_pc_execute} !== {3'b101, 32'h04}) begin
            errors++;
            $display("FAIL hit_ok got %h want %h",
                     {btb_update, flush, fetch_ready, target_pc_execute}, {3'b101, 32'h04});
        end
        checks++;
        if (stat_correct !== (STATS ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL hit_stat_correct got %0d want %0d", stat_correct, STATS ? 1 : 0);
        end
    endtask

    task automatic test_nt_hit();
        do_reset();
        push_one(32'h74, 1'b1, 32'h64);
        resolve(1'b1, 1'b0, 32'h64);
        checks++;
        if ({btb_update, flush, branch_taken_execute} !== 3'b110) begin
            errors++;
            $display("FAIL nt_strobes got %b want 110", {btb_update, flush, branch_taken_execute});
        end
        checks++;
        if ({target_pc_execute, redirect_pc} !== {32'h78, 32'h78}) begin
            errors++;
            $display("FAIL nt_data got %h want 0000007800000078", {target_pc_execute, redirect_pc});
        end
    endtask

    task automatic test_full_and_invalidate();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_one(32'h100 + 32'(4 * i), 1'b0, 32'h0);
        checks++;
        if (fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", fetch_ready);
        end
        // Push while full is dropped; the pop frees one slot.
        fetch_valid = 1; fetch_pc = 32'h999; ex_valid = 1;
        step();
        idle_inputs();
        checks++;
        if ({fetch_ready, btb_update, btb_invalidate, flush} !== 4'b1000) begin
            errors++;
            $display("FAIL full_pushpop got %b want 1000",
                     {fetch_ready, btb_update, btb_invalidate, flush});
        end
        fetch_valid = 1; fetch_pc = 32'h200; fetch_btb_hit = 1; fetch_predicted_pc = 32'h300;
        ex_valid = 1;
        step();
        idle_inputs();
        push_one(32'h210, 1'b0, 32'h0);
        checks++;
        if (fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_count got ready %b want 0", fetch_ready);
        end
        resolve(1'b0, 1'b0, 32'h0);
        resolve(1'b0, 1'b0, 32'h0);
        resolve(1'b0, 1'b0, 32'h0);
        checks++;
        if ({btb_invalidate, btb_update, flush, pc_execute, redirect_pc} !==
            {3'b101, 32'h200, 32'h204}) begin
            errors++;
            $display("FAIL false_hit got %h want %h",
                     {btb_invalidate, btb_update, flush, pc_execute, redirect_pc},
                     {3'b101, 32'h200, 32'h204});
        end
    endtask

    task automatic test_underflow();
        do_reset();
        resolve(1'b1, 1'b1, 32'h40);
        checks++;
        if ({underflow_err, btb_update, flush, btb_invalidate} !== 4'b1000) begin
            errors++;
            $display("FAIL underflow got %b want 1000",
                     {underflow_err, btb_update, flush, btb_invalidate});
        end
        repeat (2) step();
        checks++;
        if (underflow_err !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky got %b want 1", underflow_err);
        end
        do_reset();
        checks++;
        if (underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear got %b want 0", underflow_err);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            fetch_valid = ($urandom_range(0, 2) != 0);
            pc = 32'($urandom_range(0, 15)) << 2;
            fetch_pc = pc;
            fetch_btb_hit = $urandom_range(0, 1) != 0;
            fetch_predicted_pc = ($urandom_range(0, 1) != 0) ? pc + 32'd4
                                                             : 32'($urandom_range(0, 15)) << 2;
            ex_valid = ($urandom_range(0, 1) != 0);
            ex_is_branch = ($urandom_range(0, 1) != 0);
            ex_taken = ($urandom_range(0, 1) != 0);
            ex_target = 32'($urandom_range(0, 15)) << 2;
            if ((n % 80) == 0) ex_valid = 1;
            step();
            checks++;
            if ({btb_update, btb_invalidate, flush, fetch_ready, underflow_err} !==
                {m_bu, m_inv, m_fl, model_ready(), m_uf}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d got %b want %b", n,
                         {btb_update, btb_invalidate, flush, fetch_ready, underflow_err},
                         {m_bu, m_inv, m_fl, model_ready(), m_uf});
            end
            checks++;
            if ({pc_execute, target_pc_execute, branch_taken_execute, redirect_pc} !==
                {m_pc, m_tgt, m_tk, m_rd}) begin
                errors++;
                $display("FAIL rand_data cyc %0d got %h want %h", n,
                         {pc_execute, target_pc_execute, branch_taken_execute, redirect_pc},
                         {m_pc, m_tgt, m_tk, m_rd});
            end
            checks++;
            if ({stat_branches, stat_hits, stat_correct} !==
                (STATS ? {m_sb, m_sh, m_sc} : 96'd0)) begin
                errors++;
                $display("FAIL rand_stats cyc %0d got %h want %h", n,
                         {stat_branches, stat_hits, stat_correct},
                         STATS ? {m_sb, m_sh, m_sc} : 96'd0);
            end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_taken_miss();
        test_taken_hit();
        test_nt_hit();
        test_full_and_invalidate();
        test_underflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
